// File: rtl/cache_arb_pkg.sv
// Shared types and the wrap-around priority scan used by the coherence bus arbiter.
// Both the primary and the snoop selection use the same scan.
package cache_arb_pkg;
    localparam int MAX_PROC = 8;

    typedef logic [2:0] idx_t;

    typedef enum logic {P_IDLE, P_OWN} p_state_t;
    typedef enum logic [1:0] {S_IDLE, S_SNOOP, S_MEM} s_state_t;

    typedef struct packed {
        logic valid;
        idx_t idx;
    } pick_t;

    // Scan downward in offset so the smallest offset from start is the last hit kept.
    function automatic pick_t rr_pick(input logic [MAX_PROC-1:0] req, input idx_t start, input int n);
        pick_t p;
        int    j;
        p = '0;
        for (int i = MAX_PROC - 1; i >= 0; i--) begin
            if (i < n) begin
                j = (int'(start) + i) % n;
                if (req[j]) begin
                    p.valid = 1'b1;
                    p.idx   = idx_t'(j);
                end
            end
        end
        return p;
    endfunction

    function automatic idx_t next_idx(input idx_t i, input int n);
        return (int'(i) + 1 >= n) ? '0 : idx_t'(i + 3'd1);
    endfunction
endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Com_Bus request/grant bundle; master is the arbiter side, slave the caches and memory.
interface cache_bus_arbiter_if #(parameter int NUM_PROC = 8);
    logic [NUM_PROC-1:0] Com_Bus_Req_proc;
    logic [NUM_PROC-1:0] Com_Bus_Req_snoop;
    logic                Mem_snoop_req;
    logic [NUM_PROC-1:0] Com_Bus_Gnt_proc;
    logic [NUM_PROC-1:0] Com_Bus_Gnt_snoop;
    logic                Mem_snoop_gnt;
    logic                Arb_timeout;

    modport master (
        input  Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
        output Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt, Arb_timeout
    );

    modport slave (
        output Com_Bus_Req_proc, Com_Bus_Req_snoop, Mem_snoop_req,
        input  Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt, Arb_timeout
    );
endinterface

// File: rtl/rr_pick_logic.sv
// Combinational rotate-priority encoder: first set bit of req at or after start, wrapping.
module rr_pick_logic
    import cache_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    input  idx_t         start,
    output logic         valid,
    output idx_t         idx
);
    logic [MAX_PROC-1:0] req_ext;
    pick_t               p;

    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        p              = rr_pick(req_ext, start, N);
    end

    assign valid = p.valid;
    assign idx   = p.idx;
endmodule

// File: rtl/cache_bus_arbiter.sv
// Round-robin Com_Bus arbiter: primary owner grant plus a nested snoop/memory data slot.
// All grants and the hold-timeout pulse are registered.
module cache_bus_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_PROC = 8,
    parameter int MAX_HOLD = 255
) (
    input  logic                clk,
    input  logic                rst,
    cache_bus_arbiter_if.master bus
);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    p_state_t            p_state;
    s_state_t            s_state;
    idx_t                owner, snoop_idx, rr_ptr;
    logic [7:0]          hold_cnt;
    logic [NUM_PROC-1:0] gnt_proc, gnt_snoop;
    logic                mem_gnt, tmo;

    logic                p_valid, s_valid;
    idx_t                p_idx, s_idx;
    logic [NUM_PROC-1:0] owner_oh, snoop_cand;

    function automatic logic [NUM_PROC-1:0] onehot(input idx_t i);
        return {{(NUM_PROC-1){1'b0}}, 1'b1} << i;
    endfunction

    // The owner's own snoop request never competes for the data slot.
    assign owner_oh   = onehot(owner);
    assign snoop_cand = bus.Com_Bus_Req_snoop & ~owner_oh;

    rr_pick_logic #(.N(NUM_PROC)) u_pick_proc (
        .req   (bus.Com_Bus_Req_proc),
        .start (rr_ptr),
        .valid (p_valid),
        .idx   (p_idx)
    );

    rr_pick_logic #(.N(NUM_PROC)) u_pick_snoop (
        .req   (snoop_cand),
        .start (next_idx(owner, NUM_PROC)),
        .valid (s_valid),
        .idx   (s_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_state   <= P_IDLE;
            s_state   <= S_IDLE;
            owner     <= '0;
            snoop_idx <= '0;
            rr_ptr    <= '0;
            hold_cnt  <= '0;
            gnt_proc  <= '0;
            gnt_snoop <= '0;
            mem_gnt   <= 1'b0;
            tmo       <= 1'b0;
        end else begin
            tmo <= 1'b0;
            case (p_state)
                P_IDLE: begin
                    if (p_valid) begin
                        p_state  <= P_OWN;
                        owner    <= p_idx;
                        gnt_proc <= onehot(p_idx);
                        hold_cnt <= '0;
                    end
                end
                P_OWN: begin
                    if (!bus.Com_Bus_Req_proc[owner]) begin
                        // Owner release beats any pending secondary activity.
                        p_state   <= P_IDLE;
                        rr_ptr    <= next_idx(owner, NUM_PROC);
                        gnt_proc  <= '0;
                        s_state   <= S_IDLE;
                        gnt_snoop <= '0;
                        mem_gnt   <= 1'b0;
                    end else begin
                        if (hold_cnt != 8'hFF) begin
                            hold_cnt <= hold_cnt + 8'd1;
                            if (hold_cnt + 8'd1 == HOLD_LIM) tmo <= 1'b1;
                        end
                        case (s_state)
                            S_IDLE: begin
                                if (s_valid) begin
                                    s_state   <= S_SNOOP;
                                    snoop_idx <= s_idx;
                                    gnt_snoop <= onehot(s_idx);
                                end else if (bus.Mem_snoop_req) begin
                                    s_state <= S_MEM;
                                    mem_gnt <= 1'b1;
                                end
                            end
                            S_SNOOP: begin
                                if (!bus.Com_Bus_Req_snoop[snoop_idx]) begin
                                    s_state   <= S_IDLE;
                                    gnt_snoop <= '0;
                                end
                            end
                            S_MEM: begin
                                if (!bus.Mem_snoop_req) begin
                                    s_state <= S_IDLE;
                                    mem_gnt <= 1'b0;
                                end
                            end
                            default: s_state <= S_IDLE;
                        endcase
                    end
                end
                default: p_state <= P_IDLE;
            endcase
        end
    end

    assign bus.Com_Bus_Gnt_proc  = gnt_proc;
    assign bus.Com_Bus_Gnt_snoop = gnt_snoop;
    assign bus.Mem_snoop_gnt     = mem_gnt;
    assign bus.Arb_timeout       = tmo;
endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Bench for cache_bus_arbiter: directed scenarios plus random traffic against a
// transaction-level model (owner / data-slot holder / hold count as plain integers).
module tb_cache_bus_arbiter;
    localparam int N  = 8;
    localparam int MH = 4;

    logic clk, rst;
    int   vecs = 0, errs = 0;

    cache_bus_arbiter_if #(.NUM_PROC(N)) bus ();

    cache_bus_arbiter #(.NUM_PROC(N), .MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: sec 0=none 1=snooper 2=memory
    bit m_busy, m_to;
    int m_owner, m_rr, m_sec, m_sidx, m_cnt;

    task automatic model_reset();
        m_busy = 0; m_to = 0; m_owner = 0; m_rr = 0; m_sec = 0; m_sidx = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit found;
        m_to = 0;
        if (!m_busy) begin
            for (int k = 0; k < N; k++)
                if (!m_busy && bus.Com_Bus_Req_proc[(m_rr + k) % N]) begin
                    m_busy = 1; m_owner = (m_rr + k) % N; m_cnt = 0;
                end
        end else if (!bus.Com_Bus_Req_proc[m_owner]) begin
            m_busy = 0; m_rr = (m_owner + 1) % N; m_sec = 0;
        end else begin
            if (m_cnt < 255) begin
                m_to  = (m_cnt + 1 == MH);
                m_cnt = m_cnt + 1;
            end
            if (m_sec == 0) begin
                found = 0;
                for (int k = 1; k < N; k++)
                    if (!found && bus.Com_Bus_Req_snoop[(m_owner + k) % N]) begin
                        found = 1; m_sec = 1; m_sidx = (m_owner + k) % N;
                    end
                if (!found && bus.Mem_snoop_req) m_sec = 2;
            end else if (m_sec == 1) begin
                if (!bus.Com_Bus_Req_snoop[m_sidx]) m_sec = 0;
            end else begin
                if (!bus.Mem_snoop_req) m_sec = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.Com_Bus_Req_proc = '0; bus.Com_Bus_Req_snoop = '0; bus.Mem_snoop_req = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        vecs++; if (bus.Com_Bus_Gnt_proc !== 8'h00) begin errs++; $display("FAIL reset_gnt_proc: got %h want 00", bus.Com_Bus_Gnt_proc); end
        vecs++; if (bus.Com_Bus_Gnt_snoop !== 8'h00) begin errs++; $display("FAIL reset_gnt_snoop: got %h want 00", bus.Com_Bus_Gnt_snoop); end
        vecs++; if (bus.Mem_snoop_gnt !== 1'b0) begin errs++; $display("FAIL reset_mem_gnt: got %b want 0", bus.Mem_snoop_gnt); end
        vecs++; if (bus.Arb_timeout !== 1'b0) begin errs++; $display("FAIL reset_timeout: got %b want 0", bus.Arb_timeout); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        bus.Com_Bus_Req_proc = 8'b0000_0101;
        tick();
        vecs++; if (bus.Com_Bus_Gnt_proc !== 8'b0000_0001) begin errs++; $display("FAIL basic_first: got %b want 00000001", bus.Com_Bus_Gnt_proc); end
        bus.Com_Bus_Req_proc = 8'b0000_0100;
        tick();
        vecs++; if (bus.Com_Bus_Gnt_proc !== 8'b0000_0000) begin errs++; $display("FAIL basic_dead: got %b want 00000000", bus.Com_Bus_Gnt_proc); end
        tick();
        vecs++; if (bus.Com_Bus_Gnt_proc !== 8'b0000_0100) begin errs++; $display("FAIL basic_next: got %b want 00000100", bus.Com_Bus_Gnt_proc); end
    endtask

    task automatic test_fairness();
        logic [7:0] e;
        do_reset();
        bus.Com_Bus_Req_proc = 8'hFF;
        tick();
        for (int g = 0; g < 9; g++) begin
            e = 8'h01 << (g % N);
            vecs++; if (bus.Com_Bus_Gnt_proc !== e) begin errs++; $display("FAIL fair_grant%0d: got %b want %b", g, bus.Com_Bus_Gnt_proc, e); end
            tick(); tick();
            bus.Com_Bus_Req_proc[g % N] = 1'b0;
            tick();
            vecs++; if (bus.Com_Bus_Gnt_proc !== 8'h00) begin errs++; $display("FAIL fair_dead%0d: got %b want 00000000", g, bus.Com_Bus_Gnt_proc); end
            bus.Com_Bus_Req_proc[g % N] = 1'b1;
            tick();
        end
    endtask

    task automatic test_snoop_priority();
        do_reset();
        bus.Com_Bus_Req_proc = 8'b0000_0100;
        tick();
        bus.Com_Bus_Req_snoop = 8'b0010_0100;
        bus.Mem_snoop_req = 1'b1;
        tick();
        vecs++; if (bus.Com_Bus_Gnt_snoop !== 8'b0010_0000) begin errs++; $display("FAIL snoop_pri_gnt: got %b want 00100000", bus.Com_Bus_Gnt_snoop); end
        vecs++; if (bus.Mem_snoop_gnt !== 1'b0) begin errs++; $display("FAIL snoop_pri_mem: got %b want 0", bus.Mem_snoop_gnt); end
        vecs++; if (bus.Com_Bus_Gnt_proc !== 8'b0000_0100) begin errs++; $display("FAIL snoop_pri_owner: got %b want 00000100", bus.Com_Bus_Gnt_proc); end
    endtask

    task automatic test_mem_hold();
        do_reset();
        bus.Com_Bus_Req_proc = 8'b0000_1000;
        tick();
        bus.Mem_snoop_req = 1'b1;
        tick();
        vecs++; if (bus.Mem_snoop_gnt !== 1'b1) begin errs++; $display("FAIL mem_grant: got %b want 1", bus.Mem_snoop_gnt); end
        bus.Com_Bus_Req_snoop = 8'b0010_0000;
        tick(); tick();
        vecs++; if ({bus.Mem_snoop_gnt, bus.Com_Bus_Gnt_snoop} !== 9'b1_0000_0000) begin errs++; $display("FAIL mem_no_preempt: got %b want 100000000", {bus.Mem_snoop_gnt, bus.Com_Bus_Gnt_snoop}); end
        bus.Mem_snoop_req = 1'b0;
        tick();
        vecs++; if ({bus.Mem_snoop_gnt, bus.Com_Bus_Gnt_snoop} !== 9'b0) begin errs++; $display("FAIL mem_idle_gap: got %b want 000000000", {bus.Mem_snoop_gnt, bus.Com_Bus_Gnt_snoop}); end
        tick();
        vecs++; if (bus.Com_Bus_Gnt_snoop !== 8'b0010_0000) begin errs++; $display("FAIL mem_then_snoop: got %b want 00100000", bus.Com_Bus_Gnt_snoop); end
    endtask

    task automatic test_release();
        do_reset();
        bus.Com_Bus_Req_proc = 8'b0000_0001;
        tick();
        bus.Com_Bus_Req_snoop = 8'b0000_0010;
        tick();
        vecs++; if (bus.Com_Bus_Gnt_snoop !== 8'b0000_0010) begin errs++; $display("FAIL rel_snoop_gnt: got %b want 00000010", bus.Com_Bus_Gnt_snoop); end
        bus.Com_Bus_Req_proc = 8'b0;
        bus.Mem_snoop_req = 1'b1;
        tick();
        vecs++; if ({bus.Com_Bus_Gnt_proc, bus.Com_Bus_Gnt_snoop, bus.Mem_snoop_gnt} !== 17'b0) begin errs++; $display("FAIL rel_all_drop: got %b want 0", {bus.Com_Bus_Gnt_proc, bus.Com_Bus_Gnt_snoop, bus.Mem_snoop_gnt}); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.Com_Bus_Req_proc = 8'b0000_0001;
        tick();
        for (int k = 1; k < 10; k++) begin
            tick();
            vecs++; if (bus.Arb_timeout !== (k == MH)) begin errs++; $display("FAIL timeout_c%0d: got %b want %b", k, bus.Arb_timeout, (k == MH)); end
        end
        vecs++; if (bus.Com_Bus_Gnt_proc !== 8'b0000_0001) begin errs++; $display("FAIL timeout_kept: got %b want 00000001", bus.Com_Bus_Gnt_proc); end
        #2 rst = 1'b1;
        model_reset();
        #1;
        vecs++; if ({bus.Com_Bus_Gnt_proc, bus.Com_Bus_Gnt_snoop, bus.Mem_snoop_gnt, bus.Arb_timeout} !== 18'b0) begin errs++; $display("FAIL midhold_rst: got %b want 0", {bus.Com_Bus_Gnt_proc, bus.Com_Bus_Gnt_snoop, bus.Mem_snoop_gnt, bus.Arb_timeout}); end
        @(negedge clk);
        rst = 1'b0;
        bus.Com_Bus_Req_proc = 8'b1000_0010;
        tick();
        vecs++; if (bus.Com_Bus_Gnt_proc !== 8'b0000_0010) begin errs++; $display("FAIL restart_rr0: got %b want 00000010", bus.Com_Bus_Gnt_proc); end
    endtask

    task automatic test_random();
        logic [7:0] ep, es;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) begin
                if (bus.Com_Bus_Req_proc[b]) begin if ($urandom_range(5) == 0) bus.Com_Bus_Req_proc[b] = 1'b0; end
                else if ($urandom_range(7) == 0) bus.Com_Bus_Req_proc[b] = 1'b1;
                if (bus.Com_Bus_Req_snoop[b]) begin if ($urandom_range(2) == 0) bus.Com_Bus_Req_snoop[b] = 1'b0; end
                else if ($urandom_range(15) == 0) bus.Com_Bus_Req_snoop[b] = 1'b1;
            end
            if ($urandom_range(3) == 0) bus.Mem_snoop_req = ~bus.Mem_snoop_req;
            tick();
            ep = m_busy ? (8'h01 << m_owner) : 8'h00;
            es = (m_busy && m_sec == 1) ? (8'h01 << m_sidx) : 8'h00;
            vecs++; if (bus.Com_Bus_Gnt_proc !== ep) begin errs++; $display("FAIL rnd_proc c%0d: got %b want %b", c, bus.Com_Bus_Gnt_proc, ep); end
            vecs++; if (bus.Com_Bus_Gnt_snoop !== es) begin errs++; $display("FAIL rnd_snoop c%0d: got %b want %b", c, bus.Com_Bus_Gnt_snoop, es); end
            vecs++; if (bus.Mem_snoop_gnt !== (m_busy && m_sec == 2)) begin errs++; $display("FAIL rnd_mem c%0d: got %b want %b", c, bus.Mem_snoop_gnt, (m_busy && m_sec == 2)); end
            vecs++; if (bus.Arb_timeout !== m_to) begin errs++; $display("FAIL rnd_timeout c%0d: got %b want %b", c, bus.Arb_timeout, m_to); end
            vecs++; if ($countones({bus.Com_Bus_Gnt_snoop, bus.Mem_snoop_gnt}) > 1) begin errs++; $display("FAIL rnd_onehot c%0d: got %b want at most one bit", c, {bus.Com_Bus_Gnt_snoop, bus.Mem_snoop_gnt}); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.Com_Bus_Req_proc = '0; bus.Com_Bus_Req_snoop = '0; bus.Mem_snoop_req = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_fairness();
        test_snoop_priority();
        test_mem_hold();
        test_release();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
